// File: rtl/lvds_tx_pkg.sv
// Shared types and constants for the LVDS transmit frame scheduler.
package lvds_tx_pkg;

    localparam int unsigned LEN_W    = 7;
    localparam logic [7:0]  K28_5    = 8'hBC;
    localparam logic [7:0]  HDR0_DEF = 8'hEE;
    localparam logic [7:0]  HDR1_DEF = 8'h33;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_H0,
        ST_H1,
        ST_LEN,
        ST_PAY,
        ST_CHK,
        ST_GAP
    } state_e;

    // Requested payload length limited to the configured maximum.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input logic [LEN_W-1:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/lvds_tx_frame_sched_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that was not
// granted last wins; grant is zero unless advance is set.
module lvds_rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    input  logic       advance,
    output logic [1:0] grant
);

    // One-hot grant selection.
    always_comb begin
        grant = '0;
        if (advance) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_ptr ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

endmodule

// File: rtl/lvds_tx_frame_sched.sv
// Frame scheduler for the 8b/10b LVDS transmit path.
// Frame: HDR0, HDR1, length, payload, [checksum], then a comma gap.
// Optional checksum symbol enabled by defining LVDS_TX_CHECKSUM_EN.
module lvds_tx_frame_sched
    import lvds_tx_pkg::*;
#(
    parameter int unsigned MAX_LEN  = 125,
    parameter int unsigned MIN_IDLE = 8,
    parameter logic [7:0]  HDR0     = HDR0_DEF,
    parameter logic [7:0]  HDR1     = HDR1_DEF,
    parameter logic [7:0]  COMMA    = K28_5
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             link_en,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic [7:0]       d0,
    input  logic [7:0]       d1,
    output logic             rd0,
    output logic             rd1,
    output logic [1:0]       grant,
    output logic [1:0]       done,
    output logic             abort,
    output logic [7:0]       tx_data,
    output logic             tx_k
);

    localparam int unsigned      IW         = $clog2(MIN_IDLE + 1);
    localparam logic [IW-1:0]    MIN_IDLE_C = IW'(MIN_IDLE);
    localparam logic [LEN_W-1:0] MAX_LEN_C  = LEN_W'(MAX_LEN);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_k_q, tx_k_d;
    logic [1:0]       done_q, done_d;
    logic             abort_q, abort_d;
`ifdef LVDS_TX_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic             arb_adv;
    logic [1:0]       arb_grant;
    logic [LEN_W-1:0] grant_len;
    logic [7:0]       pay_byte;
    logic             pop;
    logic             end_frame;
    logic             in_frame;

    assign arb_adv   = (state_q == ST_IDLE) && link_en &&
                       (idle_cnt_q >= MIN_IDLE_C) && (req != 2'b00);
    assign grant_len = clamp_len(arb_grant[1] ? len1 : len0, MAX_LEN_C);
    assign pay_byte  = owner_q ? d1 : d0;
    assign in_frame  = state_q inside {ST_H0, ST_H1, ST_LEN, ST_PAY, ST_CHK};

    lvds_rr_arb2 u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .advance (arb_adv),
        .grant   (arb_grant)
    );

    // Next state and next registered symbol; payload pops run one cycle ahead
    // of the byte appearing on tx_data because d0/d1 are show-ahead.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = idle_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        tx_data_d  = COMMA;
        tx_k_d     = 1'b1;
        done_d     = '0;
        abort_d    = 1'b0;
        pop        = 1'b0;
        end_frame  = 1'b0;
`ifdef LVDS_TX_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (idle_cnt_q < MIN_IDLE_C) idle_cnt_d = idle_cnt_q + 1'b1;
                if (arb_grant != 2'b00) begin
                    owner_d   = arb_grant[1];
                    rr_ptr_d  = arb_grant[1];
                    len_d     = grant_len;
                    state_d   = ST_H0;
                    tx_data_d = HDR0;
                    tx_k_d    = 1'b0;
`ifdef LVDS_TX_CHECKSUM_EN
                    csum_d    = {1'b0, grant_len};
`endif
                end
            end
            ST_H0: begin
                state_d   = ST_H1;
                tx_data_d = HDR1;
                tx_k_d    = 1'b0;
            end
            ST_H1: begin
                state_d   = ST_LEN;
                tx_data_d = {1'b0, len_q};
                tx_k_d    = 1'b0;
            end
            ST_LEN: begin
                if (len_q != '0) begin
                    state_d    = ST_PAY;
                    pop        = 1'b1;
                    tx_data_d  = pay_byte;
                    tx_k_d     = 1'b0;
                    byte_cnt_d = LEN_W'(1);
`ifdef LVDS_TX_CHECKSUM_EN
                    csum_d     = csum_q + pay_byte;
`endif
                end else begin
                    end_frame = 1'b1;
                end
            end
            ST_PAY: begin
                if (byte_cnt_q < len_q) begin
                    pop        = 1'b1;
                    tx_data_d  = pay_byte;
                    tx_k_d     = 1'b0;
                    byte_cnt_d = byte_cnt_q + 1'b1;
`ifdef LVDS_TX_CHECKSUM_EN
                    csum_d     = csum_q + pay_byte;
`endif
                end else begin
                    end_frame = 1'b1;
                end
            end
`ifdef LVDS_TX_CHECKSUM_EN
            ST_CHK: begin
                state_d    = ST_GAP;
                done_d     = owner_q ? 2'b10 : 2'b01;
                idle_cnt_d = IW'(1);
            end
`endif
            ST_GAP: begin
                state_d = ST_IDLE;
                if (idle_cnt_q < MIN_IDLE_C) idle_cnt_d = idle_cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // idle_cnt loads 1 on gap entry: the gap comma itself is the first idle symbol.
        if (end_frame) begin
`ifdef LVDS_TX_CHECKSUM_EN
            state_d   = ST_CHK;
            tx_data_d = csum_q;
            tx_k_d    = 1'b0;
`else
            state_d    = ST_GAP;
            done_d     = owner_q ? 2'b10 : 2'b01;
            idle_cnt_d = IW'(1);
`endif
        end

        // Link loss overrides whatever the frame would have done this cycle.
        if (in_frame && !link_en) begin
            state_d    = ST_GAP;
            tx_data_d  = COMMA;
            tx_k_d     = 1'b1;
            pop        = 1'b0;
            done_d     = '0;
            abort_d    = 1'b1;
            idle_cnt_d = IW'(1);
        end
    end

    // State and registered outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            len_q      <= '0;
            byte_cnt_q <= '0;
            idle_cnt_q <= MIN_IDLE_C;
            rr_ptr_q   <= 1'b0;
            tx_data_q  <= COMMA;
            tx_k_q     <= 1'b1;
            done_q     <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_k_q     <= tx_k_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

`ifdef LVDS_TX_CHECKSUM_EN
    // Running checksum over length and payload bytes.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) csum_q <= '0;
        else        csum_q <= csum_d;
    end
`endif

    // Grant shows the arbiter decision while idle, then the frame owner until the gap.
    always_comb begin
        case (state_q)
            ST_IDLE: grant = arb_grant;
            ST_GAP:  grant = '0;
            default: grant = owner_q ? 2'b10 : 2'b01;
        endcase
    end

    assign rd0     = pop & ~owner_q;
    assign rd1     = pop & owner_q;
    assign done    = done_q;
    assign abort   = abort_q;
    assign tx_data = tx_data_q;
    assign tx_k    = tx_k_q;

endmodule
